// File: rtl/skew_count_checker_if.sv
// skew_count_checker_if: stimulus and status bundle between the counter under test and its checker
interface skew_count_checker_if #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 16
);
  logic EN, CLR, TC, LOCKED, ERR, TC_ERR;
  logic [WIDTH-1:0] Q, EXP_Q, OBS_Q;
  logic [ERR_W-1:0] ERR_CNT;
  modport master(output EN, CLR, Q, TC, input LOCKED, ERR, ERR_CNT, TC_ERR, EXP_Q, OBS_Q);
  modport slave(input EN, CLR, Q, TC, output LOCKED, ERR, ERR_CNT, TC_ERR, EXP_Q, OBS_Q);
endinterface

// File: rtl/skew_count_checker.sv
// skew_count_checker: checks that a skew-clocked counter steps by one per CLK and that TC tracks Q.
// Define SKEW_CHK_CAPTURE_EN to record expected/observed Q at the first locked violation.
module skew_count_checker #(
  parameter int WIDTH    = 16,
  parameter int SYNC_CNT = 4,
  parameter int ERR_W    = 16
) (
  input logic CLK,
  input logic RESET,
  skew_count_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;
  state_t state;
  logic [WIDTH-1:0] s_q, p_q, nxt_q;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0] sync_cnt;
  logic s_tc, s_vld, inc_ok, tc_ok, viol, locked, err, tc_err;
  assign nxt_q  = p_q + WIDTH'(1);
  assign inc_ok = s_q == nxt_q;
  assign tc_ok  = s_tc == (&s_q);
  assign viol   = !inc_ok || !tc_ok;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_q   <= '0;
      p_q   <= '0;
      s_tc  <= 1'b0;
      s_vld <= 1'b0;
    end else begin
      s_q   <= bus.Q;
      s_tc  <= bus.TC;
      p_q   <= s_q;
      s_vld <= bus.EN && state != IDLE;
    end
  end
  // a violation coinciding with CLR is dropped because CLR wins the priority chain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      sync_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      tc_err   <= 1'b0;
    end else if (bus.CLR) begin
      state    <= bus.EN ? SYNC : IDLE;
      sync_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      tc_err   <= 1'b0;
    end else if (!bus.EN) begin
      state    <= IDLE;
      sync_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          state    <= SYNC;
          sync_cnt <= '0;
        end
        SYNC: if (s_vld) begin
          if (!inc_ok) sync_cnt <= '0;
          else if (sync_cnt == 4'(SYNC_CNT - 1)) begin
            state    <= LOCK;
            locked   <= 1'b1;
            sync_cnt <= '0;
          end else sync_cnt <= sync_cnt + 4'd1;
        end
        LOCK: if (viol) begin
          state   <= SYNC;
          locked  <= 1'b0;
          err     <= 1'b1;
          err_cnt <= err_cnt + ERR_W'(!(&err_cnt));
          tc_err  <= tc_err | !tc_ok;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.LOCKED  = locked;
  assign bus.ERR     = err;
  assign bus.ERR_CNT = err_cnt;
  assign bus.TC_ERR  = tc_err;
`ifdef SKEW_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_exp, cap_obs;
  logic cap_done;
  always_ff @(posedge CLK) begin
    if (RESET || bus.CLR) begin
      cap_exp  <= '0;
      cap_obs  <= '0;
      cap_done <= 1'b0;
    end else if (bus.EN && state == LOCK && viol && !cap_done) begin
      cap_exp  <= nxt_q;
      cap_obs  <= s_q;
      cap_done <= 1'b1;
    end
  end
  assign bus.EXP_Q = cap_exp;
  assign bus.OBS_Q = cap_obs;
`else
  assign bus.EXP_Q = '0;
  assign bus.OBS_Q = '0;
`endif
endmodule
